dmem_pipe: RTL and testbench
============================

# dmem_pipe

Parametrised pipelined data memory for the FROG core's memory stage. Accepts byte-addressed load/store requests over a valid/ready handshake and performs size-aware lane alignment, sign/zero extension and misalignment/range checking. Returns in-order responses after a configurable read latency, with full backpressure. Successor to the single-cycle byte-enable word array; the core's MEM stage talks to it directly.

## Interface
- DATA_W, 32, word width in bits; must be 32 or 64
- DEPTH_WORDS, 256, number of DATA_W words; power of two
- RD_LATENCY, 1, cycles from request handshake to response valid; legal range 1..4
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W=64)
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  DATA_W  store data, right-aligned (bits [8·2^size-1:0] significant)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  DATA_W  load data, right-aligned and extended; 0 for stores and errors
- rsp_err  out  2  0 = ok, 1 = misaligned, 2 = out of range, 3 = parity

## Operation
- Byte offset = req_addr[log2(DATA_W/8)-1:0]; word index = the next log2(DEPTH_WORDS) bits.
- Out of range: any req_addr bit above the word index is set.
- Misaligned: the offset is not a multiple of 2^req_size, or req_size=3 with DATA_W=32.
- Error priority: misaligned over out of range. An errored store writes nothing.
- Store: byte enables are generated from size and offset, and wdata is shifted left by offset·8. Enabled bytes are committed on the handshake edge. Every store produces exactly one response with rdata=0.
- Load: the word is read on the handshake edge. The addressed bytes are shifted down by offset·8 and extended per req_unsigned.
- Ordering: responses return strictly in request order. Loads and stores share one pipeline of RD_LATENCY stages.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new bytes.
- Backpressure: the pipeline advances when the last stage is empty or rsp_ready=1.
  - req_ready = advance (combinational).
  - When the pipeline is stalled, all stages hold and no write commits.
- Memory contents are not reset and are X until written.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, all stage valids 0. req_ready=1 from the first cycle after reset deasserts.
- Accept at edge N gives rsp_valid at edge N+RD_LATENCY, provided no stall occurs.
- Throughput: one request per cycle when rsp_ready is held at 1.
- Stall: rsp_valid, rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
- Reset asserted mid-operation: all in-flight responses are discarded. Stores already committed remain in the array.
- A store accepted in the same cycle that reset asserts does not commit.

## Configuration
- DMEM_PARITY_EN defined:
  - One even-parity bit is stored per byte and written alongside the data.
  - On a load, a parity mismatch in any byte actually read sets rsp_err=3 and forces rdata=0.
  - The parity array is not reset.
- DMEM_PARITY_EN undefined: no parity storage is built, and rsp_err never takes the value 3.

## Structure
- dmem_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - error enum (ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_PARITY)
  - response stage struct (valid, err, size, unsigned, offset, raw word)
- Sub-module dmem_lane_align: purely combinational. Generates write byte enables and shifted write data, and aligns and extends load data. It is instantiated once on the write side and once on the read side.
- The array and pipeline registers use the shared DFF macros.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load signed byte from 0x13 → rsp_rdata=0xFFFFFFDE, err=0; unsigned half from 0x12 → 0x0000DEAD.
- Store byte 0x55 to 0x11 over the previous word, then load word from 0x10 → 0xDEAD55EF, with the response RD_LATENCY cycles after accept.
- Load half from 0x03 → err=1, rdata=0. Store word to 0x400 with DEPTH_WORDS=256 → err=2, and a later load from 0x000 shows no change.
- RD_LATENCY=3 with back-to-back loads and rsp_ready=0 for 5 cycles → req_ready drops once the last stage fills, outputs hold, and all responses drain in order without loss or duplication.
- Assert rst_n low with 2 loads in flight → rsp_valid=0 immediately. After release, earlier stored data still reads back correctly.
- With DMEM_PARITY_EN defined, force a stored parity bit to flip on byte 1 of 0x20, then load word → err=3. A load of byte 0x20 (byte 0) → err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the FROG data memory: access sizes, response error codes,
// the response pipeline stage record and the alignment check helper.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_PARITY   = 2'd3
  } err_e;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  // Sized for the widest build; narrower builds use the low bits of raw/par.
  typedef struct packed {
    logic                  valid;
    logic                  we;
    err_e                  err;
    size_e                 size;
    logic                  uns;
    logic [2:0]            offset;
    logic [MAX_DATA_W-1:0] raw;
    logic [MAX_BYTES-1:0]  par;
  } stage_t;

  function automatic logic is_misaligned(input size_e size, input logic [2:0] off,
                                         input logic wide);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return (|(off & mask)) || (size == SZ_D && !wide);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: write byte enables and shifted store data,
// plus right-alignment and sign/zero extension of load data.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_e                         i_size,
  input  logic [$clog2(DATA_W/8)-1:0]   i_offset,
  input  logic                          i_uns,
  input  logic [DATA_W-1:0]             i_wdata,
  input  logic [DATA_W-1:0]             i_rraw,
  output logic [DATA_W/8-1:0]           o_be,
  output logic [DATA_W-1:0]             o_wdata,
  output logic [DATA_W-1:0]             o_rdata
);

  localparam int NB = DATA_W / 8;

  logic [7:0]          w_mask;
  logic [DATA_W-1:0]   w_sh;
  logic signed [7:0]   w_b;
  logic signed [15:0]  w_h;
  logic signed [31:0]  w_w;

  assign o_wdata = i_wdata << {i_offset, 3'b000};
  assign w_sh    = i_rraw >> {i_offset, 3'b000};
  assign w_b     = w_sh[7:0];
  assign w_h     = w_sh[15:0];
  assign w_w     = w_sh[31:0];

  always_comb begin
    case (i_size)
      SZ_B:    w_mask = 8'h01;
      SZ_H:    w_mask = 8'h03;
      SZ_W:    w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
    o_be = NB'({8'h00, w_mask} << i_offset);
  end

  // Signed casts sign-extend; unsigned casts zero-extend.
  always_comb begin
    case (i_size)
      SZ_B:    o_rdata = i_uns ? DATA_W'(w_sh[7:0])  : DATA_W'(w_b);
      SZ_H:    o_rdata = i_uns ? DATA_W'(w_sh[15:0]) : DATA_W'(w_h);
      SZ_W:    o_rdata = i_uns ? DATA_W'(w_sh[31:0]) : DATA_W'(w_w);
      default: o_rdata = w_sh;
    endcase
  end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined byte-addressed data memory with in-order responses and backpressure.
// Optional per-byte even parity storage and checking: define DMEM_PARITY_EN.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  stage_t            r_stg_p [RD_LATENCY];

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_range;
  err_e              w_req_err;
  logic              w_adv;
  logic              w_acc;
  logic              w_wr;
  logic [NB-1:0]     w_wr_be;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_unused_wr_rdata;
  logic [NB-1:0]     w_rd_par;
  stage_t            w_new;
  stage_t            w_last;
  logic [NB-1:0]     w_rd_be;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_unused_rd_wdata;
  logic              w_par_bad;
  err_e              w_rsp_err;
  logic              w_unused;

  assign w_off   = req_addr[OFF_W-1:0];
  assign w_idx   = req_addr[OFF_W +: IDX_W];
  assign w_range = |(req_addr >> (OFF_W + IDX_W));

  always_comb begin
    if (is_misaligned(size_e'(req_size), 3'(w_off), DATA_W == 64)) w_req_err = ERR_MISALIGN;
    else if (w_range)                                               w_req_err = ERR_RANGE;
    else                                                            w_req_err = ERR_NONE;
  end

  // The whole pipeline moves as one; a full last stage with no consumer freezes it.
  assign w_last    = r_stg_p[RD_LATENCY-1];
  assign w_adv     = !w_last.valid || rsp_ready;
  assign req_ready = w_adv && rst_n;
  assign w_acc     = req_valid && req_ready;
  assign w_wr      = w_acc && req_we && (w_req_err == ERR_NONE);

  dmem_lane_align #(.DATA_W(DATA_W)) u_wr_align (
    .i_size   (size_e'(req_size)),
    .i_offset (w_off),
    .i_uns    (req_unsigned),
    .i_wdata  (req_wdata),
    .i_rraw   ('0),
    .o_be     (w_wr_be),
    .o_wdata  (w_wr_data),
    .o_rdata  (w_unused_wr_rdata)
  );

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH_WORDS];
  assign w_rd_par = r_par[w_idx];
`else
  assign w_rd_par = '0;
`endif

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wr_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
`ifdef DMEM_PARITY_EN
          r_par[w_idx][b]        <= ^w_wr_data[b*8 +: 8];
`endif
        end
      end
    end
  end

  always_comb begin
    w_new        = '0;
    w_new.valid  = w_acc;
    w_new.we     = req_we;
    w_new.err    = w_req_err;
    w_new.size   = size_e'(req_size);
    w_new.uns    = req_unsigned;
    w_new.offset = 3'(w_off);
    w_new.raw    = 64'(r_mem[w_idx]);
    w_new.par    = 8'(w_rd_par);
  end

  // Stage p0 captures the array read on the handshake edge; later stages shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) r_stg_p[i].valid <= 1'b0;
    end else if (w_adv) begin
      r_stg_p[0] <= w_new;
      for (int i = 1; i < RD_LATENCY; i++) r_stg_p[i] <= r_stg_p[i-1];
    end
  end

  // Response stage: align and extend the raw word, then qualify.
  dmem_lane_align #(.DATA_W(DATA_W)) u_rd_align (
    .i_size   (w_last.size),
    .i_offset (w_last.offset[OFF_W-1:0]),
    .i_uns    (w_last.uns),
    .i_wdata  ('0),
    .i_rraw   (w_last.raw[DATA_W-1:0]),
    .o_be     (w_rd_be),
    .o_wdata  (w_unused_rd_wdata),
    .o_rdata  (w_rd_data)
  );

`ifdef DMEM_PARITY_EN
  always_comb begin
    w_par_bad = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (w_rd_be[b] && ((^w_last.raw[b*8 +: 8]) != w_last.par[b])) w_par_bad = 1'b1;
    end
  end
`else
  assign w_par_bad = 1'b0;
`endif

  always_comb begin
    w_rsp_err = w_last.err;
    if (w_last.err == ERR_NONE && !w_last.we && w_par_bad) w_rsp_err = ERR_PARITY;
  end

  assign rsp_valid = w_last.valid;
  assign rsp_err   = w_last.valid ? w_rsp_err : ERR_NONE;
  assign rsp_rdata = (w_last.valid && !w_last.we && w_rsp_err == ERR_NONE) ? w_rd_data : '0;

  assign w_unused = ^{w_last, w_rd_be, w_unused_wr_rdata, w_unused_rd_wdata};

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe (32-bit, 256 words, three-stage read latency).
module tb_dmem_pipe;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_err;

  dmem_pipe #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  err;
  } vec_t;

  vec_t        vecs [28];
  int          errors = 0;
  int          checks = 0;
  logic [33:0] exp_q [$];
  string       name_q [$];
  logic [33:0] m_exp;
  string       m_nm;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // In-order scoreboard: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0d, expected none", rsp_rdata, rsp_err);
      end else begin
        m_exp = exp_q.pop_front();
        m_nm  = name_q.pop_front();
        check({m_nm, "_rdata"}, rsp_rdata, m_exp[31:0]);
        check({m_nm, "_err"}, 32'(rsp_err), 32'(m_exp[33:32]));
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd, input logic [31:0] er,
                      input logic [1:0] ee, input string nm);
    logic rdy;
    int   n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL %s_accept: got no handshake, expected one within 200 cycles", nm);
    end else begin
      exp_q.push_back({ee, er});
      name_q.push_back(nm);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({nm, "_drain_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h000, 2'd2, 1'b0, 32'hCAFEF00D, 32'h00000000, 2'd0};
    vecs[1]  = '{1'b1, 32'h010, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 2'd0};
    vecs[2]  = '{1'b0, 32'h013, 2'd0, 1'b0, 32'h0,        32'hFFFFFFDE, 2'd0};
    vecs[3]  = '{1'b0, 32'h012, 2'd1, 1'b1, 32'h0,        32'h0000DEAD, 2'd0};
    vecs[4]  = '{1'b1, 32'h011, 2'd0, 1'b0, 32'h00000055, 32'h00000000, 2'd0};
    vecs[5]  = '{1'b0, 32'h010, 2'd2, 1'b0, 32'h0,        32'hDEAD55EF, 2'd0};
    vecs[6]  = '{1'b0, 32'h003, 2'd1, 1'b0, 32'h0,        32'h00000000, 2'd1};
    vecs[7]  = '{1'b1, 32'h400, 2'd2, 1'b0, 32'h12345678, 32'h00000000, 2'd2};
    vecs[8]  = '{1'b0, 32'h000, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 2'd0};
    vecs[9]  = '{1'b1, 32'h020, 2'd3, 1'b0, 32'hFFFFFFFF, 32'h00000000, 2'd1};
    vecs[10] = '{1'b0, 32'h402, 2'd2, 1'b0, 32'h0,        32'h00000000, 2'd1};
    vecs[11] = '{1'b0, 32'h010, 2'd0, 1'b1, 32'h0,        32'h000000EF, 2'd0};
    vecs[12] = '{1'b0, 32'h010, 2'd0, 1'b0, 32'h0,        32'hFFFFFFEF, 2'd0};
    vecs[13] = '{1'b0, 32'h010, 2'd1, 1'b0, 32'h0,        32'h000055EF, 2'd0};
    vecs[14] = '{1'b0, 32'h012, 2'd1, 1'b0, 32'h0,        32'hFFFFDEAD, 2'd0};
    vecs[15] = '{1'b1, 32'h016, 2'd1, 1'b0, 32'hFFFF8001, 32'h00000000, 2'd0};
    vecs[16] = '{1'b0, 32'h016, 2'd1, 1'b0, 32'h0,        32'hFFFF8001, 2'd0};
    vecs[17] = '{1'b0, 32'h016, 2'd1, 1'b1, 32'h0,        32'h00008001, 2'd0};
    vecs[18] = '{1'b1, 32'h013, 2'd0, 1'b0, 32'hAAAAAA7F, 32'h00000000, 2'd0};
    vecs[19] = '{1'b0, 32'h010, 2'd2, 1'b0, 32'h0,        32'h7FAD55EF, 2'd0};
    vecs[20] = '{1'b0, 32'h013, 2'd0, 1'b0, 32'h0,        32'h0000007F, 2'd0};
    vecs[21] = '{1'b0, 32'h10000000, 2'd0, 1'b1, 32'h0,   32'h00000000, 2'd2};
    vecs[22] = '{1'b1, 32'h3FC, 2'd2, 1'b0, 32'h01020304, 32'h00000000, 2'd0};
    vecs[23] = '{1'b0, 32'h3FD, 2'd0, 1'b1, 32'h0,        32'h00000003, 2'd0};
    vecs[24] = '{1'b1, 32'h001, 2'd1, 1'b0, 32'h0000BEEF, 32'h00000000, 2'd1};
    vecs[25] = '{1'b0, 32'h000, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 2'd0};
    vecs[26] = '{1'b0, 32'h400, 2'd2, 1'b0, 32'h0,        32'h00000000, 2'd2};
    vecs[27] = '{1'b0, 32'h001, 2'd0, 1'b0, 32'h0,        32'hFFFFFFF0, 2'd0};

    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back table vectors at full throughput.
    for (int i = 0; i < 28; i++)
      send(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
           vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));
    drain("table");

    // Response appears exactly LAT cycles after the accepting edge.
    send(1'b0, 32'h010, 2'd2, 1'b0, 32'h0, 32'h7FAD55EF, 2'd0, "lat_load");
    req_valid = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      check($sformatf("lat_valid_c%0d", k), 32'(rsp_valid), (k == LAT - 1) ? 32'd1 : 32'd0);
    end
    drain("lat");

    // Stall with the consumer blocked for 5 cycles while loads keep arriving.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    fork
      begin
        send(1'b0, 32'h010, 2'd2, 1'b0, 32'h0, 32'h7FAD55EF, 2'd0, "stall_ld0");
        send(1'b0, 32'h013, 2'd0, 1'b0, 32'h0, 32'h0000007F, 2'd0, "stall_ld1");
        send(1'b0, 32'h012, 2'd1, 1'b1, 32'h0, 32'h00007FAD, 2'd0, "stall_ld2");
        send(1'b0, 32'h000, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 2'd0, "stall_ld3");
        send(1'b0, 32'h016, 2'd1, 1'b0, 32'h0, 32'hFFFF8001, 2'd0, "stall_ld4");
        req_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        for (int k = 0; k < 5; k++) begin
          if (k != 0) @(negedge clk);
          check($sformatf("stall_valid_c%0d", k), 32'(rsp_valid), 32'd1);
          check($sformatf("stall_rdata_c%0d", k), rsp_rdata, 32'h7FAD55EF);
          check($sformatf("stall_err_c%0d", k), 32'(rsp_err), 32'd0);
          check($sformatf("stall_req_ready_c%0d", k), 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    drain("stall");

    // Reset with loads in flight discards them; stored data survives.
    send(1'b0, 32'h010, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0, "rst_ld0");
    send(1'b0, 32'h000, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0, "rst_ld1");
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'd0);
    check("rst_mid_err", 32'(rsp_err), 32'd0);
    exp_q.delete();
    name_q.delete();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h010; req_size = 2'd2;
    req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 32'h010, 2'd2, 1'b0, 32'h0, 32'h7FAD55EF, 2'd0, "after_rst_ld10");
    send(1'b0, 32'h000, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 2'd0, "after_rst_ld00");
    drain("after_rst");

`ifdef DMEM_PARITY_EN
    send(1'b1, 32'h020, 2'd2, 1'b0, 32'h11223344, 32'h0, 2'd0, "par_store");
    drain("par_store");
    dut.r_par[8][1] = ~dut.r_par[8][1];
    send(1'b0, 32'h020, 2'd2, 1'b0, 32'h0, 32'h00000000, 2'd3, "par_ld_word");
    send(1'b0, 32'h020, 2'd0, 1'b1, 32'h0, 32'h00000044, 2'd0, "par_ld_b0");
    send(1'b0, 32'h021, 2'd0, 1'b1, 32'h0, 32'h00000000, 2'd3, "par_ld_b1");
    drain("par");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
